coll_pair_scheduler: RTL and testbench

- Sits between update_module outputs and coll_det inputs.
- Buffers one frame of updated bot states (x, y, vx, vy; Q5.11, 16-bit) for NUM_BOTS bots.
- Presents every unordered pair (i<j) to the collision detector in turn, using the level in_rdy/out_rdy handshake.
- Collects the collision result for each pair into a per-bot flag vector that feeds Velocity_selector and write-back logic.

---
 rtl/coll_pair_scheduler_pkg.sv | 26 ++
 rtl/coll_pair_scheduler_if.sv | 37 +++
 rtl/coll_pair_scheduler_bot_state_bank.sv | 29 ++
 rtl/coll_pair_scheduler.sv | 148 ++++++++++++++
 tb/tb_coll_pair_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coll_pair_scheduler_pkg.sv
// Shared types and constants for the collision pair scheduler.
package coll_pair_scheduler_pkg;

  // State word width and Q5.11 fixed-point constants.
  localparam int W         = 16;
  localparam int FRAC_BITS = 11;
  localparam logic signed [W-1:0] ONE = W'(1 << FRAC_BITS);

  // One bot's kinematic state as delivered by update_module.
  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] vx;
    logic [W-1:0] vy;
  } bot_state_t;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/coll_pair_scheduler_if.sv
// Load and collision-detector handshake bundle for coll_pair_scheduler.
interface coll_pair_scheduler_if
  import coll_pair_scheduler_pkg::*;
#(
  parameter int NUM_BOTS = 3
);
  localparam int IDW = $clog2(NUM_BOTS);

  logic                ld_valid;
  logic                ld_ready;
  logic [W-1:0]        ld_x, ld_y, ld_vx, ld_vy;
  logic                cd_in_rdy;
  logic [W-1:0]        cd_xa, cd_ya, cd_vxa, cd_vya;
  logic [W-1:0]        cd_xb, cd_yb, cd_vxb, cd_vyb;
  logic [IDW-1:0]      pair_a, pair_b;
  logic                cd_out_rdy;
  logic                cd_trial;
  logic [NUM_BOTS-1:0] coll_flags;
  logic                frame_done;

  // Scheduler side.
  modport master (
    input  ld_valid, ld_x, ld_y, ld_vx, ld_vy, cd_out_rdy, cd_trial,
    output ld_ready, cd_in_rdy,
    output cd_xa, cd_ya, cd_vxa, cd_vya, cd_xb, cd_yb, cd_vxb, cd_vyb,
    output pair_a, pair_b, coll_flags, frame_done
  );

  // Environment side (update_module / coll_det).
  modport slave (
    output ld_valid, ld_x, ld_y, ld_vx, ld_vy, cd_out_rdy, cd_trial,
    input  ld_ready, cd_in_rdy,
    input  cd_xa, cd_ya, cd_vxa, cd_vya, cd_xb, cd_yb, cd_vxb, cd_vyb,
    input  pair_a, pair_b, coll_flags, frame_done
  );

endinterface

// File: rtl/coll_pair_scheduler_bot_state_bank.sv
// One frame of bot states: single write port, two combinational read ports.
module coll_pair_scheduler_bot_state_bank
  import coll_pair_scheduler_pkg::*;
#(
  parameter int NUM_BOTS = 3,
  localparam int IDW = $clog2(NUM_BOTS)
) (
  input  logic           clock,
  input  logic           we_i,
  input  logic [IDW-1:0] waddr_i,
  input  bot_state_t     wdata_i,
  input  logic [IDW-1:0] raddr_a_i,
  input  logic [IDW-1:0] raddr_b_i,
  output bot_state_t     rdata_a_o,
  output bot_state_t     rdata_b_o
);

  bot_state_t mem_q [NUM_BOTS];

  // Write the loaded entry.
  // NOTE: storage has no reset; every entry is rewritten before it is read in a frame.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/coll_pair_scheduler.sv
// Buffers a frame of bot states and walks every unordered pair through coll_det.
module coll_pair_scheduler
  import coll_pair_scheduler_pkg::*;
#(
  parameter int NUM_BOTS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  coll_pair_scheduler_if.master bus
);

  localparam int IDW = $clog2(NUM_BOTS);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_BOTS - 1);
  localparam logic [IDW-1:0] LAST_A   = IDW'(NUM_BOTS - 2);

  sched_state_t        state_q, state_d;
  logic [IDW-1:0]      ld_cnt_q, ld_cnt_d;
  logic [IDW-1:0]      a_q, a_d, b_q, b_d;
  bot_state_t          cd_a_q, cd_a_d, cd_b_q, cd_b_d;
  logic                cd_in_rdy_q, cd_in_rdy_d;
  logic [NUM_BOTS-1:0] flags_q, flags_d;
  logic                bank_we;
  bot_state_t          bank_wdata, bank_rd_a, bank_rd_b;

  assign bank_wdata = '{x: bus.ld_x, y: bus.ld_y, vx: bus.ld_vx, vy: bus.ld_vy};

  coll_pair_scheduler_bot_state_bank #(.NUM_BOTS(NUM_BOTS)) u_bank (
    .clock     (clock),
    .we_i      (bank_we),
    .waddr_i   (ld_cnt_q),
    .wdata_i   (bank_wdata),
    .raddr_a_i (a_q),
    .raddr_b_i (b_q),
    .rdata_a_o (bank_rd_a),
    .rdata_b_o (bank_rd_b)
  );

  // FSM state register.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  // Next-state and datapath updates: load counting, pair walk, flag collection.
  // NOTE: every _d gets its hold value first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    cd_a_d      = cd_a_q;
    cd_b_d      = cd_b_q;
    cd_in_rdy_d = cd_in_rdy_q;
    flags_d     = flags_q;
    bank_we     = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (bus.ld_valid) begin
          bank_we = 1'b1;
          if (ld_cnt_q == '0) flags_d = '0;
          if (ld_cnt_q == LAST_IDX) begin
            ld_cnt_d = '0;
            a_d      = '0;
            b_d      = IDW'(1);
            state_d  = ST_ISSUE;
          end else begin
            ld_cnt_d = ld_cnt_q + IDW'(1);
          end
        end
      end
      ST_ISSUE: begin
        cd_a_d      = bank_rd_a;
        cd_b_d      = bank_rd_b;
        cd_in_rdy_d = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.cd_out_rdy) begin
          if (bus.cd_trial) begin
            flags_d[a_q] = 1'b1;
            flags_d[b_q] = 1'b1;
          end
          cd_in_rdy_d = 1'b0;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        // coll_det must drop out_rdy before the next request goes out.
        if (!bus.cd_out_rdy) begin
          if (a_q == LAST_A && b_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            if (b_q == LAST_IDX) begin
              a_d = a_q + IDW'(1);
              b_d = a_q + IDW'(2);
            end else begin
              b_d = b_q + IDW'(1);
            end
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        ld_cnt_d = '0;
        state_d  = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      ld_cnt_q    <= '0;
      a_q         <= '0;
      b_q         <= IDW'(1);
      cd_a_q      <= '0;
      cd_b_q      <= '0;
      cd_in_rdy_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      ld_cnt_q    <= ld_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cd_a_q      <= cd_a_d;
      cd_b_q      <= cd_b_d;
      cd_in_rdy_q <= cd_in_rdy_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.ld_ready   = (state_q == ST_LOAD);
  assign bus.frame_done = (state_q == ST_DONE);
  assign bus.cd_in_rdy  = cd_in_rdy_q;
  assign bus.coll_flags = flags_q;
  assign bus.pair_a     = a_q;
  assign bus.pair_b     = b_q;
  assign bus.cd_xa      = cd_a_q.x;
  assign bus.cd_ya      = cd_a_q.y;
  assign bus.cd_vxa     = cd_a_q.vx;
  assign bus.cd_vya     = cd_a_q.vy;
  assign bus.cd_xb      = cd_b_q.x;
  assign bus.cd_yb      = cd_b_q.y;
  assign bus.cd_vxb     = cd_b_q.vx;
  assign bus.cd_vyb     = cd_b_q.vy;

endmodule

// File: tb/tb_coll_pair_scheduler.sv
// Randomized self-checking bench: a 3-bot and a 4-bot scheduler share one
// stimulus/response path selected by sel; a pair-list model checks them.
module tb_coll_pair_scheduler;
  import coll_pair_scheduler_pkg::*;

  typedef struct {int a; int b;} pair_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  bit   sel   = 1'b0;

  logic        ld_valid = 1'b0;
  logic [15:0] ld_x = '0, ld_y = '0, ld_vx = '0, ld_vy = '0;
  logic        cd_out_rdy = 1'b0, cd_trial = 1'b0;

  logic         o_ld_ready, o_in_rdy, o_done;
  logic [127:0] o_data;
  logic [1:0]   o_pa, o_pb;
  logic [15:0]  o_flags;

  coll_pair_scheduler_if #(.NUM_BOTS(3)) if3 ();
  coll_pair_scheduler_if #(.NUM_BOTS(4)) if4 ();

  coll_pair_scheduler #(.NUM_BOTS(3)) dut3 (.clock(clock), .reset(reset), .bus(if3));
  coll_pair_scheduler #(.NUM_BOTS(4)) dut4 (.clock(clock), .reset(reset), .bus(if4));

  assign if3.ld_valid   = ld_valid & ~sel;
  assign if4.ld_valid   = ld_valid & sel;
  assign if3.cd_out_rdy = cd_out_rdy & ~sel;
  assign if4.cd_out_rdy = cd_out_rdy & sel;
  assign if3.cd_trial   = cd_trial;
  assign if4.cd_trial   = cd_trial;
  assign if3.ld_x = ld_x;  assign if3.ld_y = ld_y;  assign if3.ld_vx = ld_vx;  assign if3.ld_vy = ld_vy;
  assign if4.ld_x = ld_x;  assign if4.ld_y = ld_y;  assign if4.ld_vx = ld_vx;  assign if4.ld_vy = ld_vy;

  assign o_ld_ready = sel ? if4.ld_ready   : if3.ld_ready;
  assign o_in_rdy   = sel ? if4.cd_in_rdy  : if3.cd_in_rdy;
  assign o_done     = sel ? if4.frame_done : if3.frame_done;
  assign o_pa       = sel ? if4.pair_a     : if3.pair_a;
  assign o_pb       = sel ? if4.pair_b     : if3.pair_b;
  assign o_flags    = sel ? 16'(if4.coll_flags) : 16'(if3.coll_flags);
  assign o_data = sel ?
    {if4.cd_xa, if4.cd_ya, if4.cd_vxa, if4.cd_vya, if4.cd_xb, if4.cd_yb, if4.cd_vxb, if4.cd_vyb} :
    {if3.cd_xa, if3.cd_ya, if3.cd_vxa, if3.cd_vya, if3.cd_xb, if3.cd_yb, if3.cd_vxb, if3.cd_vyb};

  always #5 clock = ~clock;

  // Reference model state.
  logic [15:0] bx [16], by [16], bvx [16], bvy [16];
  bit          trial_mask [4][4];
  pair_t       exp_q [$];
  pair_t       cur = '{0, 1};
  logic [15:0] exp_flags = '0;
  int          n_req = 0;
  int          done_cnt = 0;
  bit          check_en = 1'b0;
  bit          prev_in_rdy = 1'b0;

  // Responder controls.
  bit resp_en = 1'b0, noise_en = 1'b0, force_out = 1'b0;
  int resp_d = 4, resp_extra = 0, hold_left = 0, wait_cnt = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] exp_data(input int a, input int b);
    return {bx[a], by[a], bvx[a], bvy[a], bx[b], by[b], bvx[b], bvy[b]};
  endfunction

  // Expected pair list and flags for one frame, straight from the pair rules.
  task automatic build_frame(input int n);
    exp_q.delete();
    exp_flags = '0;
    for (int a = 0; a < n; a++)
      for (int b = a + 1; b < n; b++) begin
        exp_q.push_back('{a, b});
        if (trial_mask[a][b]) begin
          exp_flags[a] = 1'b1;
          exp_flags[b] = 1'b1;
        end
      end
  endtask

  task automatic clear_mask();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) trial_mask[a][b] = 1'b0;
  endtask

  // Compare process: request sequence, bit-exact pair data, flags at frame end.
  always @(negedge clock) begin
    if (check_en && !reset) begin
      if (o_in_rdy && !prev_in_rdy) begin
        if (exp_q.size() == 0) check("extra_request", 128'(1), 128'(0));
        else begin
          cur = exp_q.pop_front();
          n_req++;
        end
      end
      if (o_in_rdy) begin
        check("pair_idx", 128'({o_pa, o_pb}), 128'({2'(cur.a), 2'(cur.b)}));
        check("pair_data", o_data, exp_data(cur.a, cur.b));
      end
      if (o_done) begin
        done_cnt++;
        check("frame_flags", 128'(o_flags), 128'(exp_flags));
        check("pairs_left", 128'(exp_q.size()), 128'(0));
      end
    end
    prev_in_rdy = o_in_rdy;
  end

  // coll_det stand-in: answers resp_d cycles into a request, optionally holds out_rdy.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (force_out) begin
        cd_out_rdy = 1'b1;
        cd_trial   = 1'b1;
        hold_left  = 0;
        wait_cnt   = 0;
      end else if (hold_left > 0) begin
        hold_left--;
        cd_trial = 1'($urandom);
        if (hold_left == 0) cd_out_rdy = 1'b0;
      end else if (resp_en && o_in_rdy) begin
        if (wait_cnt >= resp_d - 1) begin
          cd_out_rdy = 1'b1;
          cd_trial   = trial_mask[cur.a][cur.b];
          hold_left  = 1 + resp_extra;
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
          cd_out_rdy = 1'b0;
          cd_trial   = 1'($urandom);
        end
      end else begin
        wait_cnt   = 0;
        cd_trial   = 1'($urandom);
        cd_out_rdy = noise_en ? 1'($urandom) : 1'b0;
      end
    end
  end

  task automatic load_frame(input int n, input int extra_beats, input bit gaps, input bit fixed_x);
    @(posedge clock);
    #1;
    for (int i = 0; i < n + extra_beats; i++) begin
      if (gaps && i < n && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
        ld_x = 16'($urandom); ld_y = 16'($urandom); ld_vx = 16'($urandom); ld_vy = 16'($urandom);
        @(posedge clock);
        #1;
      end
      ld_valid = 1'b1;
      ld_x  = fixed_x ? 16'(ONE * (i + 1)) : 16'($urandom);
      ld_y  = 16'($urandom);
      ld_vx = 16'($urandom);
      ld_vy = 16'($urandom);
      if (i < n) begin
        bx[i] = ld_x; by[i] = ld_y; bvx[i] = ld_vx; bvy[i] = ld_vy;
      end
      if (i == n - 1) noise_en = 1'b0;
      @(negedge clock);
      check("ld_ready", 128'(o_ld_ready), 128'(i < n));
      if (i == 1) check("flags_cleared_on_load", 128'(o_flags), 128'(0));
      @(posedge clock);
      #1;
    end
    ld_valid = 1'b0;
  endtask

  task automatic run_frame(input int n, input int d, input int extra, input int extra_beats,
                           input bit gaps, input bit fixed_x);
    int d0;
    int guard;
    build_frame(n);
    resp_d     = d;
    resp_extra = extra;
    n_req      = 0;
    d0         = done_cnt;
    noise_en   = 1'b1;
    resp_en    = 1'b1;
    load_frame(n, extra_beats, gaps, fixed_x);
    guard = 0;
    while (done_cnt == d0 && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 3000) check("frame_timeout", 128'(0), 128'(1));
    repeat (2) @(negedge clock);
    check("done_pulse_cycles", 128'(done_cnt - d0), 128'(1));
    check("req_count", 128'(n_req), 128'(n * (n - 1) / 2));
    check("ld_ready_after", 128'(o_ld_ready), 128'(1));
  endtask

  initial begin
    int guard;
    int n;
    clear_mask();
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      #1;
      check("rst_ld_ready", 128'(o_ld_ready), 128'(1));
      check("rst_in_rdy", 128'(o_in_rdy), 128'(0));
      check("rst_data", o_data, 128'(0));
      check("rst_pair", 128'({o_pa, o_pb}), 128'(4'b0001));
      check("rst_flags", 128'(o_flags), 128'(0));
      check("rst_done", 128'(o_done), 128'(0));
    end
    sel      = 1'b0;
    reset    = 1'b0;
    check_en = 1'b1;

    // No collisions, fixed x values.
    run_frame(3, 4, 0, 0, 1'b0, 1'b1);
    check("t1_flags", 128'(o_flags), 128'(3'b000));

    // Only (0,2) collides; flags hold while idle.
    trial_mask[0][2] = 1'b1;
    run_frame(3, 4, 0, 0, 1'b0, 1'b1);
    check("t2_flags", 128'(o_flags), 128'(3'b101));
    repeat (5) @(negedge clock);
    check("t2_flags_held", 128'(o_flags), 128'(3'b101));

    // out_rdy held 3 extra cycles after each result.
    clear_mask();
    trial_mask[1][2] = 1'b1;
    run_frame(3, 4, 3, 0, 1'b1, 1'b0);
    check("t3_flags", 128'(o_flags), 128'(3'b110));

    // Reset during WAIT of (0,2), then a late out_rdy/trial pulse.
    clear_mask();
    trial_mask[0][1] = 1'b1;
    build_frame(3);
    resp_d = 4; resp_extra = 0; noise_en = 1'b0; resp_en = 1'b1;
    load_frame(3, 0, 1'b0, 1'b0);
    guard = 0;
    while (!(o_in_rdy && cur.a == 0 && cur.b == 2) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    check("reach_wait_02", 128'(guard < 200), 128'(1));
    check("pre_reset_flags", 128'(o_flags), 128'(3'b011));
    check_en  = 1'b0;
    resp_en   = 1'b0;
    reset     = 1'b1;
    force_out = 1'b1;
    @(negedge clock);
    check("rst_mid_in_rdy", 128'(o_in_rdy), 128'(0));
    check("rst_mid_flags", 128'(o_flags), 128'(0));
    check("rst_mid_ld_ready", 128'(o_ld_ready), 128'(1));
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("post_rst_in_rdy", 128'(o_in_rdy), 128'(0));
      check("post_rst_flags", 128'(o_flags), 128'(0));
      check("post_rst_done", 128'(o_done), 128'(0));
    end
    force_out = 1'b0;
    @(negedge clock);
    exp_q.delete();
    check_en = 1'b1;

    // ld_valid held for 5 beats: only 3 accepted.
    clear_mask();
    trial_mask[0][1] = 1'b1;
    run_frame(3, 2, 0, 2, 1'b0, 1'b0);
    check("t5_flags", 128'(o_flags), 128'(3'b011));

    // Four bots: (1,3) and (2,3) collide.
    sel = 1'b1;
    clear_mask();
    trial_mask[1][3] = 1'b1;
    trial_mask[2][3] = 1'b1;
    run_frame(4, 3, 0, 0, 1'b0, 1'b0);
    check("t6_flags", 128'(o_flags), 128'(4'b1110));

    // Randomized frames on both instances.
    for (int f = 0; f < 8; f++) begin
      sel = bit'($urandom_range(0, 1));
      n   = sel ? 4 : 3;
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) trial_mask[a][b] = ($urandom_range(0, 3) == 0);
      run_frame(n, $urandom_range(2, 5), $urandom_range(0, 2), $urandom_range(0, 1), 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
